// File: rtl/sensor_nivel_caixa_pkg.sv
// Shared types and constants for the tank-level sensor: FSM states, 2-bit level values,
// valid 3-bit probe codes {alta,media,baixa}, and code decoding helpers.
package sensor_nivel_pkg;

  typedef enum logic [2:0] {
    ST_VAZIO,
    ST_BAIXO,
    ST_MEDIO,
    ST_CHEIO,
    ST_INCONS,
    ST_FALHA
  } estado_t;

  localparam logic [1:0] NIVEL_VAZIO = 2'd0;
  localparam logic [1:0] NIVEL_BAIXO = 2'd1;
  localparam logic [1:0] NIVEL_MEDIO = 2'd2;
  localparam logic [1:0] NIVEL_CHEIO = 2'd3;

  localparam logic [2:0] COD_VAZIO = 3'b000;
  localparam logic [2:0] COD_BAIXO = 3'b001;
  localparam logic [2:0] COD_MEDIO = 3'b011;
  localparam logic [2:0] COD_CHEIO = 3'b111;

  function automatic logic codigo_valido(input logic [2:0] cod);
    return (cod == COD_VAZIO) || (cod == COD_BAIXO) ||
           (cod == COD_MEDIO) || (cod == COD_CHEIO);
  endfunction

  // Only meaningful for valid codes; wet probes always fill from the bottom up.
  function automatic logic [1:0] nivel_de(input logic [2:0] cod);
    return 2'(cod[0]) + 2'(cod[1]) + 2'(cod[2]);
  endfunction

  function automatic estado_t estado_de(input logic [1:0] niv);
    case (niv)
      NIVEL_BAIXO: return ST_BAIXO;
      NIVEL_MEDIO: return ST_MEDIO;
      NIVEL_CHEIO: return ST_CHEIO;
      default:     return ST_VAZIO;
    endcase
  endfunction

endpackage

// File: rtl/sensor_nivel_caixa_if.sv
// Link between the tank-level sensor (master, producer) and the irrigation controller (slave).
interface sensor_nivel_caixa_if;
  logic       valvula_entrada;
  logic       limpa_falha;
  logic       nivel_alto;
  logic       nivel_medio;
  logic       nivel_baixo;
  logic [1:0] nivel;
  logic       nivel_mudou;
  logic       falha;
  logic       travado;

  modport master (
    input  valvula_entrada, limpa_falha,
    output nivel_alto, nivel_medio, nivel_baixo, nivel, nivel_mudou, falha, travado
  );

  modport slave (
    output valvula_entrada, limpa_falha,
    input  nivel_alto, nivel_medio, nivel_baixo, nivel, nivel_mudou, falha, travado
  );
endinterface

// File: rtl/sensor_nivel_caixa_debounce_sonda.sv
// One probe: 2-FF synchroniser followed by a debounce counter; the accepted value flips
// only after DEBOUNCE_CYCLES consecutive synchronised samples that differ from it.
module debounce_sonda #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sonda,
  output logic estavel
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      estavel <= 1'b0;
    end else begin
      sync_p0 <= sonda;
      sync_p1 <= sync_p0;
      // cnt never passes DEBOUNCE_CYCLES-1, so it cannot wrap
      if (sync_p1 == estavel) begin
        cnt <= '0;
      end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
        estavel <= sync_p1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_nivel_caixa.sv
// Tank-level sensor: debounced probes, level FSM with inconsistency fault, change pulse.
// Optional stuck-sensor watchdog enabled by defining SENSOR_TRAVADO_EN.
module sensor_nivel_caixa #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FAULT_CYCLES    = 256,
  parameter int TIMEOUT_CYCLES  = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sonda_alta,
  input  logic                  sonda_media,
  input  logic                  sonda_baixa,
  sensor_nivel_caixa_if.master  bus
);
  import sensor_nivel_pkg::*;

  localparam int FW = $clog2(FAULT_CYCLES + 1);

  logic          alto, medio, baixo;
  logic [2:0]    codigo;
  logic          valido;
  logic [1:0]    nivel_cod;
  estado_t       estado, estado_next;
  logic [FW-1:0] fcnt, fcnt_next;
  logic [1:0]    nivel_q, nivel_next, nivel_p1;
  logic          mudou_q, falha_q;

  debounce_sonda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_alta (
    .clk(clk), .rst_n(rst_n), .sonda(sonda_alta), .estavel(alto));
  debounce_sonda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_media (
    .clk(clk), .rst_n(rst_n), .sonda(sonda_media), .estavel(medio));
  debounce_sonda #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_baixa (
    .clk(clk), .rst_n(rst_n), .sonda(sonda_baixa), .estavel(baixo));

  assign codigo    = {alto, medio, baixo};
  assign valido    = codigo_valido(codigo);
  assign nivel_cod = nivel_de(codigo);

  // fcnt holds the number of consecutive invalid samples seen so far (0 in level states)
  always_comb begin
    estado_next = estado;
    fcnt_next   = fcnt;
    nivel_next  = nivel_q;
    case (estado)
      ST_FALHA: begin
        if (bus.limpa_falha && valido) begin
          estado_next = estado_de(nivel_cod);
          nivel_next  = nivel_cod;
          fcnt_next   = '0;
        end
      end
      default: begin
        if (valido) begin
          estado_next = estado_de(nivel_cod);
          nivel_next  = nivel_cod;
          fcnt_next   = '0;
        end else if (fcnt >= FW'(FAULT_CYCLES - 1)) begin
          estado_next = ST_FALHA;
        end else begin
          estado_next = ST_INCONS;
          fcnt_next   = fcnt + FW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= ST_VAZIO;
      fcnt     <= '0;
      nivel_q  <= NIVEL_VAZIO;
      nivel_p1 <= NIVEL_VAZIO;
      mudou_q  <= 1'b0;
      falha_q  <= 1'b0;
    end else begin
      estado   <= estado_next;
      fcnt     <= fcnt_next;
      nivel_q  <= nivel_next;
      nivel_p1 <= nivel_q;
      mudou_q  <= (nivel_q != nivel_p1);
      falha_q  <= (estado_next == ST_FALHA);
    end
  end

  assign bus.nivel_alto  = alto;
  assign bus.nivel_medio = medio;
  assign bus.nivel_baixo = baixo;
  assign bus.nivel       = nivel_q;
  assign bus.nivel_mudou = mudou_q;
  assign bus.falha       = falha_q;

`ifdef SENSOR_TRAVADO_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          travado_q;
  logic          subiu;
  logic          expira;

  assign subiu  = (nivel_next > nivel_q);
  assign expira = bus.valvula_entrada && !subiu && (nivel_q != NIVEL_CHEIO) &&
                  (tcnt >= TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      travado_q <= 1'b0;
    end else begin
      if (!bus.valvula_entrada || subiu) begin
        tcnt <= '0;
      end else if ((nivel_q != NIVEL_CHEIO) && (tcnt < TW'(TIMEOUT_CYCLES))) begin
        tcnt <= tcnt + TW'(1);
      end
      if (bus.limpa_falha) begin
        travado_q <= 1'b0;
      end else if (expira) begin
        travado_q <= 1'b1;
      end
    end
  end

  assign bus.travado = travado_q;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_valvula;

  assign unused_valvula = bus.valvula_entrada;
  assign bus.travado    = 1'b0;
`endif

endmodule
